// File: rtl/score_keeper.sv
// Registers the live BCD score, captures the final score on game-over and tracks the best score.
// Optional record blinking is enabled by defining SCORE_BLINK_EN.
module score_keeper #(
    parameter int unsigned DIGITS    = 2,
    parameter logic [1:0]  ST_IDLE   = 2'd0,
    parameter logic [1:0]  ST_PLAY   = 2'd1,
    parameter logic [1:0]  ST_HOLD   = 2'd2,
    parameter logic [1:0]  ST_OVER   = 2'd3,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        state,
    input  logic [4*DIGITS-1:0] score_in,
    input  logic              clr_best,
    output logic [4*DIGITS-1:0] score_out,
    output logic [4*DIGITS-1:0] final_out,
    output logic [4*DIGITS-1:0] best_out,
    output logic              new_best,
    output logic              best_flag,
    output logic              bcd_err,
    output logic              blink_on
);

    localparam int unsigned W = 4 * DIGITS;

    if (DIGITS < 1 || DIGITS > 6 || BLINK_DIV < 1 ||
        ST_IDLE == ST_PLAY || ST_IDLE == ST_HOLD || ST_IDLE == ST_OVER ||
        ST_PLAY == ST_HOLD || ST_PLAY == ST_OVER || ST_HOLD == ST_OVER) begin : g_bad_param
        $error("score_keeper: illegal parameter combination");
    end

    logic [W-1:0] san;
    logic         digit_bad;
    logic [1:0]   prev_state_q;
    logic [W-1:0] score_q, final_q, best_q;
    logic         new_best_q, best_flag_q, bcd_err_q;
    logic         over_entry, record;

    // Out-of-range digits saturate to 9 so the display never shows garbage.
    always_comb begin
        san       = '0;
        digit_bad = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (score_in[4*i +: 4] > 4'd9) begin
                san[4*i +: 4] = 4'd9;
                digit_bad     = 1'b1;
            end else begin
                san[4*i +: 4] = score_in[4*i +: 4];
            end
        end
    end

    assign over_entry = (state == ST_OVER) && (prev_state_q != ST_OVER);
    assign record     = over_entry && !clr_best && (san > best_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_state_q <= ST_IDLE;
            score_q      <= '0;
            final_q      <= '0;
            best_q       <= '0;
            new_best_q   <= 1'b0;
            best_flag_q  <= 1'b0;
            bcd_err_q    <= 1'b0;
        end else begin
            prev_state_q <= state;
            score_q      <= (state == ST_HOLD) ? '0 : san;
            new_best_q   <= record;
            if (over_entry) begin
                final_q <= san;
            end
            if (clr_best) begin
                best_q      <= '0;
                bcd_err_q   <= 1'b0;
                best_flag_q <= 1'b0;
            end else begin
                if (digit_bad && state != ST_HOLD) begin
                    bcd_err_q <= 1'b1;
                end
                if (record) begin
                    best_q      <= san;
                    best_flag_q <= 1'b1;
                end else if (state != ST_OVER) begin
                    best_flag_q <= 1'b0;
                end
            end
        end
    end

    assign score_out = score_q;
    assign final_out = final_q;
    assign best_out  = best_q;
    assign new_best  = new_best_q;
    assign best_flag = best_flag_q;
    assign bcd_err   = bcd_err_q;

`ifdef SCORE_BLINK_EN
    localparam int unsigned CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CW-1:0] blink_cnt_q;
    logic          blink_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
        end else if (!best_flag_q) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
        end else if (blink_cnt_q == CW'(BLINK_DIV - 1)) begin
            blink_cnt_q <= '0;
            blink_q     <= ~blink_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    // Display stays lit as soon as the record flag drops.
    assign blink_on = blink_q | ~best_flag_q;
`else
    assign blink_on = 1'b1;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios plus a randomized run
// checked against a digit-arithmetic reference model.
module tb_score_keeper;

    localparam int unsigned DIGITS = 2;
    localparam int unsigned BDIV   = 4;
    localparam logic [1:0] IDLE = 2'd0, PLAY = 2'd1, HOLD = 2'd2, OVER = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] state = IDLE;
    logic [7:0] score_in = '0;
    logic       clr_best = 1'b0;
    logic [7:0] score_out, final_out, best_out;
    logic       new_best, best_flag, bcd_err, blink_on;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int   m_score, m_final, m_best, m_n;
    bit   m_new, m_flag, m_err, m_blink;
    logic [1:0] m_prev;

    score_keeper #(.DIGITS(DIGITS), .BLINK_DIV(BDIV)) dut (
        .clk(clk), .rst_n(rst_n), .state(state), .score_in(score_in), .clr_best(clr_best),
        .score_out(score_out), .final_out(final_out), .best_out(best_out),
        .new_best(new_best), .best_flag(best_flag), .bcd_err(bcd_err), .blink_on(blink_on)
    );

    always #5 clk = ~clk;

    function automatic int sanitize(input int v);
        int hi, lo;
        hi = v / 16;
        lo = v % 16;
        if (hi > 9) hi = 9;
        if (lo > 9) lo = 9;
        return hi * 16 + lo;
    endfunction

    task automatic model_reset();
        m_score = 0; m_final = 0; m_best = 0; m_n = 0;
        m_new = 0; m_flag = 0; m_err = 0; m_blink = 1; m_prev = IDLE;
    endtask

    // Drive one cycle of inputs, advance past the edge and advance the model.
    task automatic step(input logic [1:0] st, input int sc, input bit clr);
        int s;
        bit bad, entry, rec, old_flag;
        state = st; score_in = sc[7:0]; clr_best = clr;
        s = sanitize(sc);
        bad = (sc / 16 > 9) || (sc % 16 > 9);
        entry = (st == OVER) && (m_prev != OVER);
        rec = entry && !clr && (s > m_best);
        old_flag = m_flag;
        m_score = (st == HOLD) ? 0 : s;
        if (entry) m_final = s;
        m_new = rec;
        if (clr) begin
            m_best = 0; m_err = 0; m_flag = 0;
        end else begin
            if (bad && st != HOLD) m_err = 1;
            if (rec) begin
                m_best = s; m_flag = 1;
            end else if (st != OVER) begin
                m_flag = 0;
            end
        end
        m_n = old_flag ? m_n + 1 : 0;
`ifdef SCORE_BLINK_EN
        m_blink = !m_flag || ((m_n / int'(BDIV)) % 2 == 0);
`else
        m_blink = 1;
`endif
        m_prev = st;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (score_out !== 8'h00) begin errors++; $display("FAIL reset_score got %h want 00", score_out); end
        checks++; if (final_out !== 8'h00) begin errors++; $display("FAIL reset_final got %h want 00", final_out); end
        checks++; if (best_out !== 8'h00) begin errors++; $display("FAIL reset_best got %h want 00", best_out); end
        checks++; if ({new_best, best_flag, bcd_err} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {new_best, best_flag, bcd_err});
        end
        checks++; if (blink_on !== 1'b1) begin errors++; $display("FAIL reset_blink got %b want 1", blink_on); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_play_hold();
        step(PLAY, 'h42, 0);
        checks++; if (score_out !== 8'h42) begin errors++; $display("FAIL play_score got %h want 42", score_out); end
        step(HOLD, 'h42, 0);
        checks++; if (score_out !== 8'h00) begin errors++; $display("FAIL hold_score got %h want 00", score_out); end
    endtask

    task automatic test_record();
        step(PLAY, 'h57, 0);
        step(OVER, 'h57, 0);
        checks++; if (final_out !== 8'h57) begin errors++; $display("FAIL rec_final got %h want 57", final_out); end
        checks++; if (best_out !== 8'h57) begin errors++; $display("FAIL rec_best got %h want 57", best_out); end
        checks++; if (new_best !== 1'b1) begin errors++; $display("FAIL rec_pulse got %b want 1", new_best); end
        checks++; if (best_flag !== 1'b1) begin errors++; $display("FAIL rec_flag got %b want 1", best_flag); end
        step(OVER, 'h11, 0);
        checks++; if (new_best !== 1'b0) begin errors++; $display("FAIL rec_pulse_end got %b want 0", new_best); end
        checks++; if (final_out !== 8'h57) begin errors++; $display("FAIL over_no_recapture got %h want 57", final_out); end
        checks++; if (best_flag !== 1'b1) begin errors++; $display("FAIL rec_flag_hold got %b want 1", best_flag); end
        step(IDLE, 'h00, 0);
        checks++; if (best_flag !== 1'b0) begin errors++; $display("FAIL rec_flag_clear got %b want 0", best_flag); end
        checks++; if (blink_on !== 1'b1) begin errors++; $display("FAIL rec_blink_idle got %b want 1", blink_on); end
    endtask

    task automatic test_repeat_game();
        step(PLAY, 'h10, 0);
        step(OVER, 'h57, 0);
        checks++; if (final_out !== 8'h57) begin errors++; $display("FAIL eq_final got %h want 57", final_out); end
        checks++; if ({new_best, best_flag} !== 2'b00) begin
            errors++; $display("FAIL eq_no_pulse got %b want 00", {new_best, best_flag});
        end
        step(PLAY, 'h30, 0);
        step(OVER, 'h60, 0);
        checks++; if (best_out !== 8'h60) begin errors++; $display("FAIL higher_best got %h want 60", best_out); end
        checks++; if (new_best !== 1'b1) begin errors++; $display("FAIL higher_pulse got %b want 1", new_best); end
        step(IDLE, 'h00, 0);
    endtask

    task automatic test_bcd_clear();
        step(PLAY, 'hA3, 0);
        checks++; if (score_out !== 8'h93) begin errors++; $display("FAIL san_score got %h want 93", score_out); end
        checks++; if (bcd_err !== 1'b1) begin errors++; $display("FAIL bcd_err_set got %b want 1", bcd_err); end
        step(HOLD, 'hFF, 0);
        step(PLAY, 'h12, 0);
        checks++; if (bcd_err !== 1'b1) begin errors++; $display("FAIL bcd_err_sticky got %b want 1", bcd_err); end
        step(OVER, 'h99, 1);
        checks++; if (best_out !== 8'h00) begin errors++; $display("FAIL clr_best got %h want 00", best_out); end
        checks++; if ({new_best, bcd_err, best_flag} !== 3'b000) begin
            errors++; $display("FAIL clr_flags got %b want 000", {new_best, bcd_err, best_flag});
        end
        checks++; if (final_out !== 8'h99) begin errors++; $display("FAIL clr_final got %h want 99", final_out); end
        step(IDLE, 'h00, 0);
    endtask

    task automatic test_blink();
        step(PLAY, 'h25, 0);
        step(OVER, 'h25, 0);
        for (int k = 0; k < 12; k++) begin
            checks++; if (blink_on !== m_blink) begin
                errors++; $display("FAIL blink cycle %0d got %b want %b", k, blink_on, m_blink);
            end
            step(OVER, 'h25, 0);
        end
        step(IDLE, 'h00, 0);
        checks++; if (blink_on !== 1'b1) begin errors++; $display("FAIL blink_leave got %b want 1", blink_on); end
    endtask

    task automatic test_reset_mid_over();
        step(PLAY, 'h30, 0);
        step(OVER, 'h30, 0);
        #3 rst_n = 1'b0;
        state = OVER;
        #1;
        model_reset();
        checks++; if ({score_out, final_out, best_out} !== 24'h0) begin
            errors++; $display("FAIL midover_reset got %h want 000000", {score_out, final_out, best_out});
        end
        checks++; if ({new_best, best_flag, bcd_err, blink_on} !== 4'b0001) begin
            errors++; $display("FAIL midover_flags got %b want 0001", {new_best, best_flag, bcd_err, blink_on});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(OVER, 'h40, 0);
        checks++; if (final_out !== 8'h40 || best_out !== 8'h40 || new_best !== 1'b1) begin
            errors++; $display("FAIL reentry got final=%h best=%h pulse=%b want 40 40 1",
                               final_out, best_out, new_best);
        end
    endtask

    task automatic test_random();
        int hi, lo;
        for (int c = 0; c < 400; c++) begin
            hi = $urandom_range(0, 10);
            lo = $urandom_range(0, 10);
            if (hi == 10) hi = $urandom_range(10, 15);
            if (lo == 10) lo = $urandom_range(10, 15);
            step(2'($urandom_range(0, 3)), hi * 16 + lo, ($urandom_range(0, 19) == 0));
            checks++; if (score_out !== m_score[7:0]) begin
                errors++; $display("FAIL rnd_score cyc %0d got %h want %h", c, score_out, m_score[7:0]);
            end
            checks++; if (final_out !== m_final[7:0]) begin
                errors++; $display("FAIL rnd_final cyc %0d got %h want %h", c, final_out, m_final[7:0]);
            end
            checks++; if (best_out !== m_best[7:0]) begin
                errors++; $display("FAIL rnd_best cyc %0d got %h want %h", c, best_out, m_best[7:0]);
            end
            checks++; if ({new_best, best_flag, bcd_err, blink_on} !== {m_new, m_flag, m_err, m_blink}) begin
                errors++; $display("FAIL rnd_flags cyc %0d got %b want %b", c,
                                   {new_best, best_flag, bcd_err, blink_on}, {m_new, m_flag, m_err, m_blink});
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_play_hold();
        test_record();
        test_repeat_game();
        test_bcd_clear();
        test_blink();
        test_reset_mid_over();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
